// File: rtl/gcd_sequencer.sv
// gcd_sequencer: iterative subtract-based GCD controller wrapped around an
// external combinational subtractor.
//
// The two working operands x/y are presented sorted to the subtractor
// (g_vec = larger, l_vec = smaller). Its difference comes back on diff_in and
// replaces x, while y takes the smaller operand. Iteration stops when either
// operand is zero or both are equal. A one-cycle done pulse then marks a valid
// result, which is held until the next accepted start.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   start    - begin a computation (only honoured in IDLE)
//   a_in     - operand A, sampled with an accepted start
//   b_in     - operand B, sampled with an accepted start
//   g_vec    - larger working operand to the subtractor (0 outside RUN)
//   l_vec    - smaller working operand to the subtractor (0 outside RUN)
//   diff_in  - subtractor return, g_vec - l_vec
//   busy     - high while iterating
//   done     - one-cycle pulse when result becomes valid
//   result   - GCD, held until the next accepted start
//   iter_cnt - (GCD_ITER_COUNT_EN only) saturating count of subtraction steps
//
// Build option: define GCD_ITER_COUNT_EN to add the iter_cnt port and counter.

module gcd_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] g_vec,
  output logic [WIDTH-1:0] l_vec,
  input  logic [WIDTH-1:0] diff_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] op_max;
  logic [WIDTH-1:0] op_min;
  logic             finish;
  logic             step;
  logic             accept;

  // Sorted view of the working operands; ties give x on both sides.
  always_comb begin
    if (x >= y) begin
      op_max = x;
      op_min = y;
    end else begin
      op_max = y;
      op_min = x;
    end
  end

  assign finish = (x == '0) || (y == '0) || (x == y);
  assign step   = (state == RUN) && !finish;
  assign accept = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (finish) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    g_vec = '0;
    l_vec = '0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      RUN: begin
        g_vec = op_max;
        l_vec = op_min;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Working operands and result
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      result <= '0;
    end else if (accept) begin
      x <= a_in;
      y <= b_in;
    end else if (state == RUN) begin
      // Priority: x zero, then y zero, then equality, else subtract.
      if (x == '0) begin
        result <= y;
      end else if (y == '0) begin
        result <= x;
      end else if (x == y) begin
        result <= x;
      end else begin
        x <= diff_in;
        y <= op_min;
      end
    end
  end

`ifdef GCD_ITER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (accept) begin
      iter_cnt <= '0;
    end else if (step && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed testbench for gcd_sequencer. The bench models the external
// subtractor (diff_in = g_vec - l_vec) and checks results, latency, pulse
// width, the start-ignore rule and reset abort against hand-computed values.

module tb_gcd_sequencer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] g_vec;
  logic [W-1:0] l_vec;
  logic [W-1:0] diff_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_cnt;
`endif

  int total = 0;
  int bad   = 0;

  gcd_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .g_vec   (g_vec),
    .l_vec   (l_vec),
    .diff_in (diff_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  // External subtractor stage
  assign diff_in = g_vec - l_vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts one computation in the current (IDLE) cycle. k counts cycles after
  // the start-sampling edge; done is expected exactly at k == lat.
  task automatic run_gcd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int lat, input int exp_iter,
                         input bit inject);
    int k;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    k = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_g"}, {24'd0, g_vec}, {24'd0, mx});
    check({tag, "_l"}, {24'd0, l_vec}, {24'd0, mn});
    while (!done && k < 400) begin
      if (inject && k == 5) begin
        start = 1'b1; a_in = 8'd4; b_in = 8'd2;
      end else if (inject && k == 6) begin
        start = 1'b0; a_in = '0; b_in = '0;
      end
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_res"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_g_done"}, {24'd0, g_vec}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check({tag, "_iter"}, {24'd0, iter_cnt}, exp_iter);
`else
    if (exp_iter < 0) $display("note: negative iteration count in %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {24'd0, result}, {24'd0, exp_res});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", {24'd0, result}, 32'd0);
    check("rst_g", {24'd0, g_vec}, 32'd0);
    check("rst_l", {24'd0, l_vec}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_gcd("g10_5",  8'd10,  8'd5,  8'd5,  3,   1,   1'b0);
    run_gcd("g25_7",  8'd25,  8'd7,  8'd1,  9,   7,   1'b0);
    run_gcd("g12_12", 8'd12,  8'd12, 8'd12, 2,   0,   1'b0);
    run_gcd("g0_9",   8'd0,   8'd9,  8'd9,  2,   0,   1'b0);
    run_gcd("g0_0",   8'd0,   8'd0,  8'd0,  2,   0,   1'b0);
    run_gcd("g255_1", 8'd255, 8'd1,  8'd1,  256, 254, 1'b1);

    // Abort a run with reset
    start = 1'b1; a_in = 8'd200; b_in = 8'd150;
    @(posedge clk); #1;
    start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_res", {24'd0, result}, 32'd0);
    check("abort_g", {24'd0, g_vec}, 32'd0);
    check("abort_l", {24'd0, l_vec}, 32'd0);
    @(posedge clk); #1;
    check("abort_nodone", {31'd0, done}, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    run_gcd("g8_12", 8'd8, 8'd12, 8'd4, 4, 2, 1'b0);

    // Back-to-back: second start lands on the IDLE cycle right after done
    run_gcd("g9_6",   8'd9,  8'd6,  8'd3, 4, 2, 1'b0);
    run_gcd("g14_21", 8'd14, 8'd21, 8'd7, 4, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
